// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates three effect requests onto one tone generator,
// stepping through a small note ROM with tick-timed notes and optional silent gaps.
module sfx_sequencer #(
    parameter int CLK_FREQ  = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int GAP_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [3:0] tone,
    output logic       busy,
    output logic [1:0] playing_id,
    output logic       done
);

    localparam int P    = CLK_FREQ / TICK_HZ;
    localparam int PW   = (P > 1) ? $clog2(P) : 1;
    localparam int TMAX = (GAP_TICKS > 63) ? GAP_TICKS : 63;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(P - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    // ROM addressed by {effect, note index}; effect 0 only uses its first slot.
    localparam logic [3:0] ROM_TONE [16] = '{
        4'd15, 4'd0,  4'd0,  4'd0,
        4'd8,  4'd10, 4'd12, 4'd15,
        4'd15, 4'd12, 4'd10, 4'd8,
        4'd0,  4'd0,  4'd0,  4'd0
    };
    localparam logic [5:0] ROM_DUR [16] = '{
        6'd5,  6'd1,  6'd1,  6'd1,
        6'd15, 6'd15, 6'd15, 6'd30,
        6'd15, 6'd15, 6'd15, 6'd30,
        6'd1,  6'd1,  6'd1,  6'd1
    };
    localparam logic ROM_LAST [16] = '{
        1'b1, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b1,
        1'b1, 1'b1, 1'b1, 1'b1
    };

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [TW-1:0] ticks;
    logic [1:0]    noteIdx;

    logic [1:0]    winner;
    logic          preempt;
    logic [3:0]    curAddr;
    logic [3:0]    lookAddr;
    logic [5:0]    curDur;
    logic [TW-1:0] durLast;
    logic          tickEnd;
    logic          noteExpire;
    logic          gapExpire;
    logic [3:0]    lookTone;

    // The lookup address serves both the start of an effect and the advance to the next note.
    always_comb begin
        winner     = req[2] ? 2'd2 : (req[1] ? 2'd1 : 2'd0);
        preempt    = (state != IDLE) && (req != 3'b000) && (winner > playing_id);
        curAddr    = {playing_id, noteIdx};
        lookAddr   = ((state == IDLE) || preempt) ? {winner, 2'd0}
                                                  : {playing_id, 2'(noteIdx + 2'd1)};
        curDur     = (ROM_DUR[curAddr] == 6'd0) ? 6'd1 : ROM_DUR[curAddr];
        durLast    = TW'(curDur) - TW'(1);
        tickEnd    = (presc == PRESC_LAST);
        noteExpire = tickEnd && (ticks == durLast);
        gapExpire  = tickEnd && (ticks == GAP_LAST);
        lookTone   = ROM_TONE[lookAddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            ticks      <= '0;
            noteIdx    <= '0;
            tone       <= 4'd0;
            busy       <= 1'b0;
            playing_id <= 2'd3;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tickEnd) begin
                presc <= '0;
                ticks <= ticks + TW'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            case (state)
                IDLE: begin
                    tone  <= 4'd0;
                    presc <= '0;
                    ticks <= '0;
                    if (req != 3'b000) begin
                        state      <= NOTE;
                        noteIdx    <= 2'd0;
                        tone       <= lookTone;
                        playing_id <= winner;
                        busy       <= 1'b1;
                    end
                end

                NOTE, GAP: begin
                    if (preempt) begin
                        state      <= NOTE;
                        noteIdx    <= 2'd0;
                        presc      <= '0;
                        ticks      <= '0;
                        tone       <= lookTone;
                        playing_id <= winner;
                    end else if ((state == NOTE) && noteExpire) begin
                        presc <= '0;
                        ticks <= '0;
                        if (ROM_LAST[curAddr]) begin
                            state      <= IDLE;
                            tone       <= 4'd0;
                            busy       <= 1'b0;
                            playing_id <= 2'd3;
                            done       <= 1'b1;
                        end else if (GAP_TICKS > 0) begin
                            state <= GAP;
                            tone  <= 4'd0;
                        end else begin
                            noteIdx <= noteIdx + 2'd1;
                            tone    <= lookTone;
                        end
                    end else if ((state == GAP) && gapExpire) begin
                        state   <= NOTE;
                        presc   <= '0;
                        ticks   <= '0;
                        noteIdx <= noteIdx + 2'd1;
                        tone    <= lookTone;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: table of request/expected-output segments driven through
// a scoreboard queue, plus hand-written reset sequences.
module tb_sfx_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [3:0] tone;
    logic       busy;
    logic [1:0] playing_id;
    logic       done;

    int nVec  = 0;
    int nFail = 0;

    sfx_sequencer #(.CLK_FREQ(1000), .TICK_HZ(100), .GAP_TICKS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tone       (tone),
        .busy       (busy),
        .playing_id (playing_id),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic       hold;
        logic [3:0] tone;
        logic       busy;
        logic [1:0] id;
        logic       done;
        int         cycles;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] tone;
        logic       busy;
        logic [1:0] id;
        logic       done;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic addVec(input logic [2:0] r, input logic h, input logic [3:0] t, input logic b,
                          input logic [1:0] i, input logic d, input int n, input string nm);
        vec_t v;
        v.req = r; v.hold = h; v.tone = t; v.busy = b; v.id = i; v.done = d;
        v.cycles = n; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic pushExp(input logic [3:0] t, input logic b, input logic [1:0] i,
                           input logic d, input string nm);
        exp_t e;
        e.tone = t; e.busy = b; e.id = i; e.done = d; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        nVec++;
        if (sb.size() == 0) begin
            nFail++;
            $display("[TB] FAIL scoreboard_empty: got tone=%0d busy=%0b id=%0d done=%0b, want a queued entry",
                     tone, busy, playing_id, done);
        end else begin
            e = sb.pop_front();
            if (tone !== e.tone || busy !== e.busy || playing_id !== e.id || done !== e.done) begin
                nFail++;
                $display("[TB] FAIL %s @%0t: got tone=%0d busy=%0b id=%0d done=%0b, want tone=%0d busy=%0b id=%0d done=%0b",
                         e.name, $time, tone, busy, playing_id, done, e.tone, e.busy, e.id, e.done);
            end
        end
    endtask

    // Each row drives its request before the first edge of the segment, then expects
    // the listed outputs after every edge of the segment.
    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < v.cycles; i++) begin
            req = (i == 0 || v.hold) ? v.req : 3'b000;
            pushExp(v.tone, v.busy, v.id, v.done, v.name);
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;

        // Beep, jingle 1, simultaneous request, preemption with dropped requests, level retrigger.
        addVec(3'b001, 0, 4'd15, 1, 2'd0, 0, 50,  "beep_note");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 1, 1,   "beep_done");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 0, 5,   "beep_idle");

        addVec(3'b010, 0, 4'd8,  1, 2'd1, 0, 150, "j1_n0");
        addVec(3'b000, 0, 4'd0,  1, 2'd1, 0, 10,  "j1_g0");
        addVec(3'b000, 0, 4'd10, 1, 2'd1, 0, 150, "j1_n1");
        addVec(3'b000, 0, 4'd0,  1, 2'd1, 0, 10,  "j1_g1");
        addVec(3'b000, 0, 4'd12, 1, 2'd1, 0, 150, "j1_n2");
        addVec(3'b000, 0, 4'd0,  1, 2'd1, 0, 10,  "j1_g2");
        addVec(3'b000, 0, 4'd15, 1, 2'd1, 0, 300, "j1_n3");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 1, 1,   "j1_done");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 0, 3,   "j1_idle");

        addVec(3'b011, 0, 4'd8,  1, 2'd1, 0, 150, "sim_n0");
        addVec(3'b000, 0, 4'd0,  1, 2'd1, 0, 10,  "sim_g0");
        addVec(3'b000, 0, 4'd10, 1, 2'd1, 0, 150, "sim_n1");
        addVec(3'b000, 0, 4'd0,  1, 2'd1, 0, 10,  "sim_g1");
        addVec(3'b000, 0, 4'd12, 1, 2'd1, 0, 150, "sim_n2");
        addVec(3'b000, 0, 4'd0,  1, 2'd1, 0, 10,  "sim_g2");
        addVec(3'b000, 0, 4'd15, 1, 2'd1, 0, 300, "sim_n3");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 1, 1,   "sim_done");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 0, 3,   "sim_idle");

        addVec(3'b010, 0, 4'd8,  1, 2'd1, 0, 150, "pre_j1_n0");
        addVec(3'b000, 0, 4'd0,  1, 2'd1, 0, 10,  "pre_j1_g0");
        addVec(3'b000, 0, 4'd10, 1, 2'd1, 0, 40,  "pre_j1_n1");
        addVec(3'b010, 0, 4'd10, 1, 2'd1, 0, 1,   "pre_same_req");
        addVec(3'b100, 0, 4'd15, 1, 2'd2, 0, 20,  "pre_j2_n0");
        addVec(3'b011, 1, 4'd15, 1, 2'd2, 0, 130, "pre_low_drop");
        addVec(3'b100, 0, 4'd0,  1, 2'd2, 0, 10,  "pre_eq_drop");
        addVec(3'b000, 0, 4'd12, 1, 2'd2, 0, 150, "pre_j2_n1");
        addVec(3'b000, 0, 4'd0,  1, 2'd2, 0, 10,  "pre_j2_g1");
        addVec(3'b000, 0, 4'd10, 1, 2'd2, 0, 150, "pre_j2_n2");
        addVec(3'b000, 0, 4'd0,  1, 2'd2, 0, 10,  "pre_j2_g2");
        addVec(3'b000, 0, 4'd8,  1, 2'd2, 0, 300, "pre_j2_n3");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 1, 1,   "pre_done");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 0, 3,   "pre_idle");

        addVec(3'b001, 1, 4'd15, 1, 2'd0, 0, 50,  "lvl_note");
        addVec(3'b001, 1, 4'd0,  0, 2'd3, 1, 1,   "lvl_done_req");
        addVec(3'b001, 0, 4'd15, 1, 2'd0, 0, 50,  "lvl_retrigger");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 1, 1,   "lvl_done");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 0, 3,   "lvl_idle");

        // Reset values while reset is held, then quiet idle with no requests.
        repeat (2) @(posedge clk);
        #1;
        pushExp(4'd0, 0, 2'd3, 0, "reset_values");
        checkOutput();
        rst = 1'b0;
        begin
            vec_t idleRow;
            idleRow.req = 3'b000; idleRow.hold = 1'b1; idleRow.tone = 4'd0; idleRow.busy = 1'b0;
            idleRow.id = 2'd3; idleRow.done = 1'b0; idleRow.cycles = 100; idleRow.name = "idle_quiet";
            applyStimulus(idleRow);
        end

        for (int k = 0; k < vecs.size(); k++)
            applyStimulus(vecs[k]);

        // Asynchronous reset in the middle of jingle 2, then a clean beep.
        vecs.delete();
        addVec(3'b111, 0, 4'd15, 1, 2'd2, 0, 30,  "rmid_j2");
        applyStimulus(vecs[0]);
        rst = 1'b1;
        #2;
        pushExp(4'd0, 0, 2'd3, 0, "rmid_async");
        checkOutput();
        @(posedge clk);
        #1;
        pushExp(4'd0, 0, 2'd3, 0, "rmid_held");
        checkOutput();
        rst = 1'b0;
        vecs.delete();
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 0, 3,   "rmid_no_done");
        addVec(3'b001, 0, 4'd15, 1, 2'd0, 0, 50,  "rmid_beep");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 1, 1,   "rmid_beep_done");
        addVec(3'b000, 0, 4'd0,  0, 2'd3, 0, 3,   "rmid_idle");
        for (int k = 0; k < vecs.size(); k++)
            applyStimulus(vecs[k]);
        req = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
